// File: rtl/regfile_seq_if.sv
// ---------------------------------------------------------------------------
// regfile_seq_if
// Purpose : Groups the signals between the instruction decoder, the
//           sequencing controller and the register-file datapath.
// Signals : s       - start request from the decoder
//           opcode  - instruction class (110 move, 101 ALU)
//           op      - sub-operation
//           w       - controller idle/ready
//           nsel    - one-hot register-field select (001 Rn, 010 Rd, 100 Rm)
//           vsel    - write-back source (00 C register, 10 imm8)
//           write   - register file write enable
//           loada   - load operand-A latch
//           loadb   - load operand-B latch
//           asel    - force ALU A input to zero
//           bsel    - ALU B input from immediate
//           loadc   - load C register
//           loads   - load status register
//           illegal - one-cycle unsupported-instruction pulse
// Modports: master - decoder/testbench side, drives the request
//           slave  - controller side, drives the datapath strobes
// ---------------------------------------------------------------------------
interface regfile_seq_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       illegal;

    modport master (
        output s, opcode, op,
        input  w, nsel, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, illegal
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, illegal
    );
endinterface

// File: rtl/regfile_seq.sv
// ---------------------------------------------------------------------------
// regfile_seq
// Purpose : Multi-cycle Moore controller that steps the 8x16 register file
//           and its datapath (A latch, B latch/shifter, ALU, C register,
//           status register) through a fixed state sequence per instruction
//           class, then returns to idle.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - regfile_seq_if.slave: start/opcode/op in, strobes out
// ---------------------------------------------------------------------------
module regfile_seq (
    input  logic           clk,
    input  logic           rst_n,
    regfile_seq_if.slave   bus
);

    typedef enum logic [3:0] {
        S_WAIT    = 4'd0,
        S_DECODE  = 4'd1,
        S_WR_IMM  = 4'd2,
        S_GET_A   = 4'd3,
        S_GET_B   = 4'd4,
        S_EXEC    = 4'd5,
        S_WR_RD   = 4'd6,
        S_STATUS  = 4'd7,
        S_ILLEGAL = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    logic [1:0] op_q, op_d;

    // Decoded views of the latched instruction, used by DECODE, GET_B and EXEC.
    logic isMovImm, isMovReg, isAdd, isAnd, isCmp, isMvn;

    always_comb begin
        isMovImm = (opcode_q == 3'b110) && (op_q == 2'b10);
        isMovReg = (opcode_q == 3'b110) && (op_q == 2'b00);
        isAdd    = (opcode_q == 3'b101) && (op_q == 2'b00);
        isAnd    = (opcode_q == 3'b101) && (op_q == 2'b10);
        isCmp    = (opcode_q == 3'b101) && (op_q == 2'b01);
        isMvn    = (opcode_q == 3'b101) && (op_q == 2'b11);
    end

    // State and instruction registers. Reset forces WAIT and clears the
    // latched instruction so nothing stale survives an aborted sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
        end
    end

    // Next-state logic. The instruction is captured only on the WAIT edge
    // that accepts a start, so decoder inputs may change freely afterwards.
    // Any encoding outside the enumerated set falls back to WAIT.
    always_comb begin
        state_d  = S_WAIT;
        opcode_d = opcode_q;
        op_d     = op_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    state_d  = S_DECODE;
                    opcode_d = bus.opcode;
                    op_d     = bus.op;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_DECODE: begin
                if (isMovImm)                 state_d = S_WR_IMM;
                else if (isMovReg || isMvn)   state_d = S_GET_B;
                else if (isAdd || isAnd || isCmp) state_d = S_GET_A;
                else                          state_d = S_ILLEGAL;
            end
            S_WR_IMM:  state_d = S_WAIT;
            S_GET_A:   state_d = S_GET_B;
            S_GET_B:   state_d = isCmp ? S_STATUS : S_EXEC;
            S_EXEC:    state_d = S_WR_RD;
            S_WR_RD:   state_d = S_WAIT;
            S_STATUS:  state_d = S_WAIT;
            S_ILLEGAL: state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase
    end

    // Moore outputs: purely a function of the current state. EXEC zeroes the
    // ALU A input for the single-operand moves (MOV reg, MVN) so the ALU
    // passes or inverts B alone.
    always_comb begin
        bus.w       = 1'b0;
        bus.nsel    = 3'b000;
        bus.vsel    = 2'b00;
        bus.write   = 1'b0;
        bus.loada   = 1'b0;
        bus.loadb   = 1'b0;
        bus.asel    = 1'b0;
        bus.bsel    = 1'b0;
        bus.loadc   = 1'b0;
        bus.loads   = 1'b0;
        bus.illegal = 1'b0;
        case (state_q)
            S_WAIT: bus.w = 1'b1;
            S_WR_IMM: begin
                bus.nsel  = 3'b001;
                bus.vsel  = 2'b10;
                bus.write = 1'b1;
            end
            S_GET_A: begin
                bus.nsel  = 3'b001;
                bus.loada = 1'b1;
            end
            S_GET_B: begin
                bus.nsel  = 3'b100;
                bus.loadb = 1'b1;
            end
            S_EXEC: begin
                bus.loadc = 1'b1;
                bus.asel  = isMovReg || isMvn;
            end
            S_WR_RD: begin
                bus.nsel  = 3'b010;
                bus.vsel  = 2'b00;
                bus.write = 1'b1;
            end
            S_STATUS:  bus.loads   = 1'b1;
            S_ILLEGAL: bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_seq.sv
// ---------------------------------------------------------------------------
// tb_regfile_seq
// Purpose : Directed self-checking bench for regfile_seq. Each instruction
//           class is started and the full output vector is compared after
//           every clock edge against hand-written per-state constants.
// ---------------------------------------------------------------------------
module tb_regfile_seq;

    logic clk = 1'b0;
    logic rst_n;

    regfile_seq_if bus ();

    regfile_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Output vector layout:
    // {w, nsel[2:0], vsel[1:0], write, loada, loadb, asel, bsel, loadc, loads, illegal}
    localparam logic [13:0] E_WAIT    = 14'b1_000_00_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_DECODE  = 14'b0_000_00_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_WR_IMM  = 14'b0_001_10_1_0_0_0_0_0_0_0;
    localparam logic [13:0] E_GET_A   = 14'b0_001_00_0_1_0_0_0_0_0_0;
    localparam logic [13:0] E_GET_B   = 14'b0_100_00_0_0_1_0_0_0_0_0;
    localparam logic [13:0] E_EXEC0   = 14'b0_000_00_0_0_0_0_0_1_0_0;
    localparam logic [13:0] E_EXEC1   = 14'b0_000_00_0_0_0_1_0_1_0_0;
    localparam logic [13:0] E_WR_RD   = 14'b0_010_00_1_0_0_0_0_0_0_0;
    localparam logic [13:0] E_STATUS  = 14'b0_000_00_0_0_0_0_0_0_1_0;
    localparam logic [13:0] E_ILLEGAL = 14'b0_000_00_0_0_0_0_0_0_0_1;

    logic [13:0] expSeq [0:7];

    // Packs the controller outputs into one vector for comparison.
    function automatic logic [13:0] outVec();
        return {bus.w, bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb,
                bus.asel, bus.bsel, bus.loadc, bus.loads, bus.illegal};
    endfunction

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [13:0] observed,
                               input logic [13:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Drives the decoder-side request signals.
    task automatic applyStimulus(input logic sIn, input logic [2:0] opc,
                                 input logic [1:0] o);
        bus.s      = sIn;
        bus.opcode = opc;
        bus.op     = o;
    endtask

    // Advances to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an instruction and checks expSeq[0..len-1] after each edge.
    // After the check index dropAt, s is dropped and opcode/op are replaced
    // by altOpc/altOp.
    task automatic runInstr(input string tag, input logic [2:0] opc,
                            input logic [1:0] o, input int len, input int dropAt,
                            input logic [2:0] altOpc, input logic [1:0] altOp);
        applyStimulus(1'b1, opc, o);
        for (int i = 0; i < len; i++) begin
            tick();
            checkOutput($sformatf("%s[%0d]", tag, i), outVec(), expSeq[i]);
            if (i == dropAt) applyStimulus(1'b0, altOpc, altOp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'b000, 2'b00);
        #2;
        checkOutput("resetOut", outVec(), E_WAIT);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle", outVec(), E_WAIT);
        tick();
        checkOutput("idleNoStart", outVec(), E_WAIT);

        // Reset arriving between edges while ADD sits in EXEC.
        expSeq = '{E_DECODE, E_GET_A, E_GET_B, E_EXEC0, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
        runInstr("addRst", 3'b101, 2'b00, 4, 0, 3'b101, 2'b00);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst", outVec(), E_WAIT);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("postRstIdle", outVec(), E_WAIT);

        // MOV Rn,#imm8.
        expSeq = '{E_DECODE, E_WR_IMM, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
        runInstr("movImm", 3'b110, 2'b10, 3, 0, 3'b110, 2'b10);

        // ADD with the decoder inputs switching to MOV imm after the start.
        expSeq = '{E_DECODE, E_GET_A, E_GET_B, E_EXEC0, E_WR_RD, E_WAIT, E_WAIT, E_WAIT};
        runInstr("add", 3'b101, 2'b00, 6, 0, 3'b110, 2'b10);

        // AND follows the same path as ADD.
        runInstr("and", 3'b101, 2'b10, 6, 0, 3'b000, 2'b00);

        // CMP updates status only.
        expSeq = '{E_DECODE, E_GET_A, E_GET_B, E_STATUS, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
        runInstr("cmp", 3'b101, 2'b01, 5, 0, 3'b000, 2'b00);

        // MVN and MOV reg skip the A latch and zero the ALU A input.
        expSeq = '{E_DECODE, E_GET_B, E_EXEC1, E_WR_RD, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
        runInstr("mvn", 3'b101, 2'b11, 5, 0, 3'b000, 2'b00);
        runInstr("movReg", 3'b110, 2'b00, 5, 0, 3'b000, 2'b00);

        // Unsupported codes pulse illegal for one cycle.
        expSeq = '{E_DECODE, E_ILLEGAL, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
        runInstr("ill110_01", 3'b110, 2'b01, 3, 0, 3'b000, 2'b00);
        runInstr("ill000_00", 3'b000, 2'b00, 3, 0, 3'b000, 2'b00);

        // 111/00 with s held high: one WAIT cycle separates the two runs.
        expSeq = '{E_DECODE, E_ILLEGAL, E_WAIT, E_DECODE, E_ILLEGAL, E_WAIT, E_WAIT, E_WAIT};
        runInstr("illHeld", 3'b111, 2'b00, 6, 3, 3'b111, 2'b00);
        tick();
        checkOutput("illHeldIdle", outVec(), E_WAIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
